// File: rtl/mul_pkg.sv
// mul_pkg: shared op/state encodings and default width for seq_mul_unit.
package mul_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/seq_mul_unit_adder.sv
// seq_mul_unit_adder: n-bit ripple-carry adder; carry-out is not needed by the multiplier.
module seq_mul_unit_adder #(
  parameter int n = 64
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] s
);
  logic c;
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-and-add RV32M MUL/MULH/MULHSU/MULHU unit.
// Optional SEQ_MUL_EARLY_TERM_EN ends the BUSY phase once the multiplier is exhausted.
module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            InValid,
  output logic            InReady,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  logic [1:0]        state, op;
  logic [2*XLEN-1:0] mcand, acc, add_a, add_b, sum;
  logic [XLEN-1:0]   mplier, abs_a, abs_b, result;
  logic [CW-1:0]     count;
  logic              neg, neg_a, neg_b, out_valid, early, fix;
  assign neg_a   = A[XLEN-1] & (Op == MUL_OP_MULH | Op == MUL_OP_MULHSU);
  assign neg_b   = B[XLEN-1] & (Op == MUL_OP_MULH);
  assign abs_a   = neg_a ? -A : A;
  assign abs_b   = neg_b ? -B : B;
  // FIX reuses the accumulator adder as a two's-complement negator
  assign fix     = state == S_FIX;
  assign add_a   = fix ? ~acc : acc;
  assign add_b   = fix ? '0 : mcand;
`ifdef SEQ_MUL_EARLY_TERM_EN
  assign early   = mplier == '0;
`else
  assign early   = 1'b0;
`endif
  assign InReady  = state == S_IDLE;
  assign OutValid = out_valid;
  assign Result   = result;
  seq_mul_unit_adder #(.n(2*XLEN)) u_full_adder_n (
    .a(add_a), .b(add_b), .ci(fix), .s(sum)
  );
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= S_IDLE;
      op        <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: if (InValid) begin
          op     <= Op;
          mcand  <= {{XLEN{1'b0}}, abs_a};
          mplier <= abs_b;
          acc    <= '0;
          neg    <= neg_a ^ neg_b;
          count  <= '0;
          state  <= S_BUSY;
        end
        S_BUSY: if (early) state <= S_FIX;
        else begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          if (neg) acc <= sum;
          state <= S_DONE;
        end
        default: if (!out_valid) begin
          out_valid <= 1'b1;
          result    <= op == MUL_OP_MUL ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
        end else if (OutReady) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed and random scoreboard bench for seq_mul_unit (XLEN=32).
module tb_seq_mul_unit;
  import mul_pkg::*;
  logic        Clock = 1'b0, ResetN = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic        InReady, OutValid;
  logic [1:0]  Op = '0;
  logic [31:0] A = '0, B = '0, Result;
  int          errors = 0, checks = 0;
  logic [31:0] sb[$];

  seq_mul_unit #(.XLEN(32)) dut (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
    .Op(Op), .A(A), .B(B), .OutValid(OutValid), .OutReady(OutReady), .Result(Result)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == MUL_OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return op == MUL_OP_MUL ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] mag;
    mag = (op == MUL_OP_MULH && b[31]) ? -b : b;
`ifdef SEQ_MUL_EARLY_TERM_EN
    if (mag == 0) return 3;
    for (int i = 31; i >= 0; i--)
      if (mag[i]) return (i == 31) ? 34 : i + 4;
    return 34;
`else
    return (mag == 0) ? 34 : 34;
`endif
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int stall);
    int n;
    logic [31:0] held;
    @(posedge Clock); #1;
    chk("in_ready_idle", InReady, 1);
    InValid = 1; Op = op; A = a; B = b;
    @(posedge Clock); #1;
    sb.push_back(exp);
    InValid = 0; Op = 2'($urandom); A = $urandom; B = $urandom;
    n = 0;
    while (!OutValid && n < 100) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("latency", n, exp_lat(op, b));
    held = Result;
    for (int i = 0; i < stall; i++) begin
      InValid = 1; A = $urandom; B = $urandom;
      @(posedge Clock); #1;
      chk("stall_valid", OutValid, 1);
      chk("stall_result", Result, held);
      chk("stall_in_ready", InReady, 0);
    end
    InValid = 0; OutReady = 1;
    chk("result", Result, sb.pop_front());
    @(posedge Clock); #1;
    OutReady = 0;
    chk("post_hs_valid", OutValid, 0);
    chk("post_hs_in_ready", InReady, 1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_result", Result, 0);
    ResetN = 1;
    run_op(MUL_OP_MUL,    32'd7,         32'd6,         32'd42,        0);
    run_op(MUL_OP_MULH,   32'h80000000,  32'h80000000,  32'h40000000,  0);
    run_op(MUL_OP_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  0);
    run_op(MUL_OP_MULHSU, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  0);
    run_op(MUL_OP_MUL,    32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  10);
    run_op(MUL_OP_MUL,    32'd123,       32'd0,         32'd0,         0);
    run_op(MUL_OP_MULH,   32'h12345678,  32'd1,         32'h00000000,  0);
    run_op(MUL_OP_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  1);
    @(posedge Clock); #1;
    InValid = 1; Op = MUL_OP_MUL; A = 32'd9; B = 32'd9;
    @(posedge Clock); #1;
    InValid = 0;
    repeat (5) @(posedge Clock);
    #1;
    ResetN = 0;
    #1;
    chk("abort_in_ready", InReady, 1);
    chk("abort_out_valid", OutValid, 0);
    chk("abort_result", Result, 0);
    @(posedge Clock); #1;
    ResetN = 1;
    run_op(MUL_OP_MULHU,  32'hDEADBEEF,  32'h01234567,  model(MUL_OP_MULHU, 32'hDEADBEEF, 32'h01234567), 2);
    for (int k = 0; k < 150; k++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = (k % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), k % 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
